bsg_manycore_io_credit_endpoint: RTL and testbench

Host-side endpoint that drives one IO-row p-port (io_link_sif_i/o column c) of the manycore array. It accepts host word requests (load/store/fence) over a valid/ready interface and formats them into manycore forward packets. It meters injection with an outstanding-credit counter and collects reverse-network responses into a host-visible response queue. A watchdog flags lost responses. One instance sits directly upstream of each IO router p-port.

---
 rtl/bsg_manycore_io_credit_endpoint_pkg.sv | 42 ++++
 rtl/bsg_manycore_io_credit_endpoint_credit_counter.sv | 72 +++++++
 rtl/bsg_manycore_io_credit_endpoint.sv | 246 ++++++++++++++++++++++++
 tb/tb_bsg_manycore_io_credit_endpoint.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_io_credit_endpoint_pkg.sv
// Shared encodings and link width helpers for the manycore host IO endpoint.
package bsg_manycore_io_credit_endpoint_pkg;

    typedef enum logic [1:0] {
        e_io_req_load  = 2'd0,
        e_io_req_store = 2'd1,
        e_io_req_fence = 2'd2,
        e_io_req_rsvd  = 2'd3
    } bsg_manycore_io_req_op_e;

    typedef enum logic [1:0] {
        e_remote_load  = 2'd0,
        e_remote_store = 2'd1
    } bsg_manycore_packet_op_e;

    typedef enum logic [1:0] {
        e_return_credit = 2'd0,
        e_return_int_wb = 2'd1
    } bsg_manycore_return_packet_type_e;

    typedef enum logic {
        e_ep_send,
        e_ep_fence
    } bsg_manycore_io_ep_state_e;

    localparam int op_ex_width_gp  = 4;
    localparam int reg_id_width_gp = 5;

    function automatic int fwd_packet_width(int a, int d, int x, int y);
        return a + 2 + op_ex_width_gp + reg_id_width_gp + d + 2*y + 2*x;
    endfunction

    function automatic int ret_packet_width(int d, int x, int y);
        return 2 + d + reg_id_width_gp + y + x;
    endfunction

    // Each direction carries {v, packet, ready for the opposite direction}.
    function automatic int link_sif_width(int a, int d, int x, int y);
        return fwd_packet_width(a, d, x, y) + ret_packet_width(d, x, y) + 4;
    endfunction

endpackage

// File: rtl/bsg_manycore_io_credit_endpoint_credit_counter.sv
// Outstanding-credit counter with a sticky watchdog for lost responses.
module bsg_manycore_io_credit_counter
    import bsg_manycore_io_credit_endpoint_pkg::*;
#(
    parameter int max_out_credits_p = 16,
    parameter int timeout_cycles_p  = 1024,
    parameter int credit_width_lp   = $clog2(max_out_credits_p+1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       send_i,
    input  logic                       return_i,
    output logic [credit_width_lp-1:0] credits_o,
    output logic                       full_o,
    output logic                       avail_o,
    output logic                       timeout_o
);

    localparam int wd_width_lp = $clog2(timeout_cycles_p);
    localparam logic [credit_width_lp-1:0] max_lp =
        credit_width_lp'(max_out_credits_p);
    localparam logic [wd_width_lp-1:0] wd_lim_lp =
        wd_width_lp'(timeout_cycles_p-1);

    logic [credit_width_lp-1:0] credits_r;
    logic [wd_width_lp-1:0]     wd_r, wd_n;
    logic                       timeout_r;
    logic                       ret_eff;

    assign full_o    = (credits_r == max_lp);
    assign avail_o   = (credits_r != '0);
    assign credits_o = credits_r;
    assign timeout_o = timeout_r;
    assign ret_eff   = return_i & ~full_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_r <= max_lp;
        end else begin
            credits_r <= credits_r
                       - credit_width_lp'(send_i)
                       + credit_width_lp'(ret_eff);
        end
    end

    always_comb begin
        wd_n = wd_r;
        if (return_i | full_o) begin
            wd_n = '0;
        end else if (wd_r != wd_lim_lp) begin
            wd_n = wd_r + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wd_r      <= '0;
            timeout_r <= 1'b0;
        end else begin
            wd_r      <= wd_n;
            timeout_r <= timeout_r | (wd_n == wd_lim_lp);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i && return_i) begin
            assert (!full_o)
            else $error("credit return with no outstanding request");
        end
    end

endmodule

// File: rtl/bsg_manycore_io_credit_endpoint.sv
// Host-side credit endpoint driving one IO-row p-port of the manycore.
module bsg_manycore_io_credit_endpoint
    import bsg_manycore_io_credit_endpoint_pkg::*;
#(
    parameter int addr_width_p      = 28,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 3,
    parameter int max_out_credits_p = 16,
    parameter int resp_fifo_els_p   = 4,
    parameter int timeout_cycles_p  = 1024,
    parameter int link_sif_width_lp = link_sif_width(
        addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    parameter int credit_width_lp   = $clog2(max_out_credits_p+1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [x_cord_width_p-1:0]    my_x_i,
    input  logic [y_cord_width_p-1:0]    my_y_i,
    input  logic                         req_v_i,
    output logic                         req_ready_o,
    input  logic [1:0]                   req_op_i,
    input  logic [addr_width_p-1:0]      req_addr_i,
    input  logic [data_width_p-1:0]      req_data_i,
    input  logic [x_cord_width_p-1:0]    req_x_i,
    input  logic [y_cord_width_p-1:0]    req_y_i,
    input  logic [link_sif_width_lp-1:0] link_sif_i,
    output logic [link_sif_width_lp-1:0] link_sif_o,
    output logic                         resp_v_o,
    output logic [data_width_p-1:0]      resp_data_o,
    input  logic                         resp_yumi_i,
    output logic [credit_width_lp-1:0]   out_credits_o,
    output logic                         idle_o,
    output logic                         timeout_o
);

    typedef struct packed {
        logic [addr_width_p-1:0]    addr;
        logic [1:0]                 op;
        logic [op_ex_width_gp-1:0]  op_ex;
        logic [reg_id_width_gp-1:0] reg_id;
        logic [data_width_p-1:0]    data;
        logic [y_cord_width_p-1:0]  src_y;
        logic [x_cord_width_p-1:0]  src_x;
        logic [y_cord_width_p-1:0]  y_cord;
        logic [x_cord_width_p-1:0]  x_cord;
    } fwd_packet_s;

    typedef struct packed {
        logic [1:0]                 pkt_type;
        logic [data_width_p-1:0]    data;
        logic [reg_id_width_gp-1:0] reg_id;
        logic [y_cord_width_p-1:0]  y_cord;
        logic [x_cord_width_p-1:0]  x_cord;
    } ret_packet_s;

    typedef struct packed {
        logic        v;
        fwd_packet_s data;
        logic        ready_and_rev;
    } fwd_link_s;

    typedef struct packed {
        logic        v;
        ret_packet_s data;
        logic        ready_and_rev;
    } rev_link_s;

    typedef struct packed {
        fwd_link_s fwd;
        rev_link_s rev;
    } link_sif_s;

    typedef struct packed {
        bsg_manycore_io_req_op_e   op;
        logic [addr_width_p-1:0]   addr;
        logic [data_width_p-1:0]   data;
        logic [x_cord_width_p-1:0] x_cord;
        logic [y_cord_width_p-1:0] y_cord;
    } req_s;

    localparam int resp_ptr_w_lp = $clog2(resp_fifo_els_p);
    localparam int resp_cnt_w_lp = $clog2(resp_fifo_els_p+1);

    link_sif_s link_in, link_out;
    assign link_in    = link_sif_i;
    assign link_sif_o = link_out;

    // Host request staging: two-entry FIFO.
    req_s       req_mem [2];
    req_s       req_in, head;
    logic       req_wptr, req_rptr;
    logic [1:0] req_cnt;
    logic       req_enq, req_deq, head_v;

    assign req_in = '{op:     bsg_manycore_io_req_op_e'(req_op_i),
                      addr:   req_addr_i,
                      data:   req_data_i,
                      x_cord: req_x_i,
                      y_cord: req_y_i};

    assign req_ready_o = reset_n_i & (req_cnt != 2'd2);
    assign req_enq     = req_v_i & req_ready_o;
    assign head_v      = (req_cnt != 2'd0);
    assign head        = req_mem[req_rptr];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            req_wptr <= 1'b0;
            req_rptr <= 1'b0;
            req_cnt  <= 2'd0;
        end else begin
            if (req_enq) req_wptr <= ~req_wptr;
            if (req_deq) req_rptr <= ~req_rptr;
            req_cnt <= req_cnt + 2'(req_enq) - 2'(req_deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_enq) req_mem[req_wptr] <= req_in;
    end

    // Credits and watchdog.
    logic fwd_v, fwd_fire, ret_fire, rev_ready;
    logic credits_full, credits_avail;

    assign fwd_fire = fwd_v & link_in.fwd.ready_and_rev;

    bsg_manycore_io_credit_counter #(
        .max_out_credits_p(max_out_credits_p),
        .timeout_cycles_p (timeout_cycles_p)
    ) counter (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .send_i   (fwd_fire),
        .return_i (ret_fire),
        .credits_o(out_credits_o),
        .full_o   (credits_full),
        .avail_o  (credits_avail),
        .timeout_o(timeout_o)
    );

    // Injection FSM.
    bsg_manycore_io_ep_state_e state_r, state_n;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state_r <= e_ep_send;
        else            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_ep_send:
                if (head_v && head.op == e_io_req_fence)
                    state_n = e_ep_fence;
            e_ep_fence:
                if (credits_full) state_n = e_ep_send;
            default: state_n = e_ep_send;
        endcase
    end

    always_comb begin
        fwd_v   = 1'b0;
        req_deq = 1'b0;
        unique case (state_r)
            e_ep_send: begin
                if (head_v) begin
                    unique case (head.op)
                        e_io_req_load, e_io_req_store: begin
                            fwd_v   = credits_avail;
                            req_deq = fwd_fire;
                        end
                        e_io_req_rsvd: req_deq = 1'b1;
                        default: ;
                    endcase
                end
            end
            e_ep_fence: req_deq = credits_full;
            default: ;
        endcase
    end

    assign idle_o = credits_full & (state_r == e_ep_send) & ~head_v;

    // Response queue fed by load returns.
    logic [data_width_p-1:0]  resp_mem [resp_fifo_els_p];
    logic [resp_ptr_w_lp-1:0] resp_wptr, resp_rptr;
    logic [resp_cnt_w_lp-1:0] resp_cnt;
    logic                     resp_full, resp_enq, resp_deq;

    assign resp_full = (resp_cnt == resp_cnt_w_lp'(resp_fifo_els_p));
    assign rev_ready = reset_n_i & ~resp_full;
    assign ret_fire  = link_in.rev.v & rev_ready;
    assign resp_enq  = ret_fire
                     & (link_in.rev.data.pkt_type == e_return_int_wb);
    assign resp_v_o    = (resp_cnt != '0);
    assign resp_deq    = resp_yumi_i & resp_v_o;
    assign resp_data_o = resp_mem[resp_rptr];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_wptr <= '0;
            resp_rptr <= '0;
            resp_cnt  <= '0;
        end else begin
            if (resp_enq)
                resp_wptr <= (resp_wptr == resp_ptr_w_lp'(resp_fifo_els_p-1))
                           ? '0 : resp_wptr + 1'b1;
            if (resp_deq)
                resp_rptr <= (resp_rptr == resp_ptr_w_lp'(resp_fifo_els_p-1))
                           ? '0 : resp_rptr + 1'b1;
            resp_cnt <= resp_cnt
                      + resp_cnt_w_lp'(resp_enq)
                      - resp_cnt_w_lp'(resp_deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (resp_enq) resp_mem[resp_wptr] <= link_in.rev.data.data;
    end

    always_comb begin
        link_out = '0;
        link_out.fwd.v           = fwd_v;
        link_out.fwd.data.addr   = head.addr;
        link_out.fwd.data.op     = (head.op == e_io_req_store)
                                 ? e_remote_store : e_remote_load;
        link_out.fwd.data.data   = head.data;
        link_out.fwd.data.src_x  = my_x_i;
        link_out.fwd.data.src_y  = my_y_i;
        link_out.fwd.data.x_cord = head.x_cord;
        link_out.fwd.data.y_cord = head.y_cord;
        link_out.rev.ready_and_rev = rev_ready;
    end

    // Inbound requests and return routing fields are not consumed here.
    logic unused_link_bits;
    assign unused_link_bits = ^{link_in.fwd.v,
                                link_in.fwd.data,
                                link_in.rev.ready_and_rev,
                                link_in.rev.data.reg_id,
                                link_in.rev.data.y_cord,
                                link_in.rev.data.x_cord};

endmodule

// File: tb/tb_bsg_manycore_io_credit_endpoint.sv
// Directed bench for the manycore host IO credit endpoint.
module tb_bsg_manycore_io_credit_endpoint;

    localparam int A  = 28;
    localparam int D  = 32;
    localparam int XW = 4;
    localparam int YW = 3;
    localparam int LW = (2 + (A+2+4+5+D+2*YW+2*XW)) + (2 + (2+D+5+YW+XW));

    localparam logic [1:0] OP_LD  = 2'd0;
    localparam logic [1:0] OP_ST  = 2'd1;
    localparam logic [1:0] OP_FN  = 2'd2;
    localparam logic [1:0] OP_RS  = 2'd3;
    localparam logic [1:0] PK_LD  = 2'd0;
    localparam logic [1:0] PK_ST  = 2'd1;
    localparam logic [1:0] RT_CR  = 2'd0;
    localparam logic [1:0] RT_WB  = 2'd1;
    localparam logic [3:0] MY_X   = 4'd5;
    localparam logic [2:0] MY_Y   = 3'd6;

    typedef struct packed {
        logic [A-1:0]  addr;
        logic [1:0]    op;
        logic [3:0]    op_ex;
        logic [4:0]    reg_id;
        logic [D-1:0]  data;
        logic [YW-1:0] src_y;
        logic [XW-1:0] src_x;
        logic [YW-1:0] y;
        logic [XW-1:0] x;
    } fwd_pkt_t;

    typedef struct packed {
        logic [1:0]    typ;
        logic [D-1:0]  data;
        logic [4:0]    reg_id;
        logic [YW-1:0] y;
        logic [XW-1:0] x;
    } ret_pkt_t;

    typedef struct packed {
        logic     fwd_v;
        fwd_pkt_t fwd;
        logic     fwd_ready;
        logic     rev_v;
        ret_pkt_t rev;
        logic     rev_ready;
    } link_t;

    typedef struct {
        logic [1:0]    op;
        logic [A-1:0]  addr;
        logic [D-1:0]  data;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [D-1:0]  rdata;
        logic          exp_v;
        logic [1:0]    exp_pop;
        logic [4:0]    exp_cred;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_v = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [A-1:0]  req_addr = '0;
    logic [D-1:0]  req_data = '0;
    logic [XW-1:0] req_x = '0;
    logic [YW-1:0] req_y = '0;
    link_t         lin, lout;
    logic          resp_v;
    logic [D-1:0]  resp_data;
    logic          resp_yumi = 1'b0;
    logic [4:0]    credits;
    logic          idle, timeout;

    int checks = 0;
    int errors = 0;
    int fires  = 0;
    int f0;
    vec_t vecs [5];

    always #5 clk = ~clk;

    bsg_manycore_io_credit_endpoint #(
        .timeout_cycles_p(8)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .my_x_i       (MY_X),
        .my_y_i       (MY_Y),
        .req_v_i      (req_v),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_x_i      (req_x),
        .req_y_i      (req_y),
        .link_sif_i   (lin),
        .link_sif_o   (lout),
        .resp_v_o     (resp_v),
        .resp_data_o  (resp_data),
        .resp_yumi_i  (resp_yumi),
        .out_credits_o(credits),
        .idle_o       (idle),
        .timeout_o    (timeout)
    );

    // A handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) begin
        if (rst_n && lout.fwd_v && lin.fwd_ready) fires++;
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_v     = 1'b0;
        resp_yumi = 1'b0;
        lin       = '0;
        lin.fwd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [A-1:0] addr,
                        input logic [D-1:0] data, input logic [XW-1:0] x,
                        input logic [YW-1:0] y);
        int n = 0;
        req_v = 1'b1; req_op = op; req_addr = addr;
        req_data = data; req_x = x; req_y = y;
        #1;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("push_wait", 64'd0, 64'd1);
        tick();
        req_v = 1'b0;
    endtask

    task automatic ret(input logic [1:0] typ, input logic [D-1:0] data);
        int n = 0;
        lin.rev_v = 1'b1; lin.rev.typ = typ; lin.rev.data = data;
        #1;
        while (!lout.rev_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ret_wait", 64'd0, 64'd1);
        tick();
        lin.rev_v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        vecs[0] = '{OP_ST, 28'h0000123, 32'hA5A5A5A5, 4'd1, 3'd2,
                    32'h0, 1'b1, PK_ST, 5'd15};
        vecs[1] = '{OP_LD, 28'h0000100, 32'h00000000, 4'd2, 3'd3,
                    32'hDEADBEEF, 1'b1, PK_LD, 5'd15};
        vecs[2] = '{OP_RS, 28'h0000055, 32'h12345678, 4'd3, 3'd1,
                    32'h0, 1'b0, PK_LD, 5'd16};
        vecs[3] = '{OP_ST, 28'hFFFFFFF, 32'hFFFFFFFF, 4'd15, 3'd7,
                    32'h0, 1'b1, PK_ST, 5'd15};
        vecs[4] = '{OP_LD, 28'h0000000, 32'h0BADF00D, 4'd0, 3'd0,
                    32'h00000001, 1'b1, PK_LD, 5'd15};

        #1;
        lin = '0;
        rst_n = 1'b0;
        req_v = 1'b1;
        #2;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_fwd_v", lout.fwd_v, 0);
        chk("rst_rev_ready", lout.rev_ready, 0);
        chk("rst_idle", idle, 1);
        do_reset();
        chk("reset_credits", credits, 16);
        chk("reset_idle", idle, 1);
        chk("reset_resp_v", resp_v, 0);
        chk("reset_timeout", timeout, 0);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rev_ready", lout.rev_ready, 1);

        // Single-request vectors.
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v = vecs[i];
            f0 = fires;
            push(v.op, v.addr, v.data, v.x, v.y);
            #1;
            chk($sformatf("v%0d_fwd_v", i), lout.fwd_v, v.exp_v);
            if (v.exp_v) begin
                chk($sformatf("v%0d_op", i), lout.fwd.op, v.exp_pop);
                chk($sformatf("v%0d_addr", i), lout.fwd.addr, v.addr);
                chk($sformatf("v%0d_data", i), lout.fwd.data, v.data);
                chk($sformatf("v%0d_xy", i),
                    {lout.fwd.x, lout.fwd.y}, {v.x, v.y});
                chk($sformatf("v%0d_src", i),
                    {lout.fwd.src_x, lout.fwd.src_y}, {MY_X, MY_Y});
                chk($sformatf("v%0d_zero", i),
                    {lout.fwd.op_ex, lout.fwd.reg_id}, 0);
            end
            tick();
            chk($sformatf("v%0d_credits", i), credits, v.exp_cred);
            chk($sformatf("v%0d_fires", i), fires - f0, v.exp_v);
            chk($sformatf("v%0d_idle", i), idle, !v.exp_v);
            if (v.exp_v) begin
                ret((v.op == OP_LD) ? RT_WB : RT_CR, v.rdata);
                #1;
                chk($sformatf("v%0d_cred_back", i), credits, 16);
                chk($sformatf("v%0d_resp_v", i), resp_v, v.op == OP_LD);
                if (v.op == OP_LD) begin
                    chk($sformatf("v%0d_resp_data", i), resp_data, v.rdata);
                    resp_yumi = 1'b1;
                    tick();
                    resp_yumi = 1'b0;
                    #1;
                    chk($sformatf("v%0d_resp_pop", i), resp_v, 0);
                end
            end
        end

        // Credit exhaustion: 17 stores, no returns.
        do_reset();
        f0 = fires;
        for (int i = 0; i < 17; i++) push(OP_ST, A'(i), D'(i), 4'd1, 3'd1);
        repeat (3) tick();
        chk("exh_fires", fires - f0, 16);
        chk("exh_credits", credits, 0);
        chk("exh_held", lout.fwd_v, 0);
        chk("exh_idle", idle, 0);
        lin.rev_v = 1'b1; lin.rev.typ = RT_CR;
        #1;
        chk("exh_before_ret", lout.fwd_v, 0);
        tick();
        lin.rev_v = 1'b0;
        #1;
        chk("exh_after_ret_v", lout.fwd_v, 1);
        chk("exh_after_ret_addr", lout.fwd.addr, 16);
        chk("exh_after_ret_cred", credits, 1);
        tick();
        chk("exh_17th_sent", fires - f0, 17);
        chk("exh_cred_zero", credits, 0);

        // Send and return on the same edge.
        do_reset();
        f0 = fires;
        push(OP_ST, 28'h10, 32'h1, 4'd1, 3'd1);
        tick();
        lin.fwd_ready = 1'b0;
        push(OP_ST, 28'h11, 32'h2, 4'd1, 3'd1);
        #1;
        chk("sim_held_v", lout.fwd_v, 1);
        lin.fwd_ready = 1'b1;
        lin.rev_v = 1'b1; lin.rev.typ = RT_CR;
        tick();
        lin.rev_v = 1'b0;
        #1;
        chk("sim_credits", credits, 15);
        chk("sim_fires", fires - f0, 2);
        ret(RT_CR, 32'h0);
        #1;
        chk("sim_final_cred", credits, 16);

        // Response queue full stalls the reverse link.
        do_reset();
        for (int i = 0; i < 5; i++) push(OP_LD, A'(32'h200 + i), 32'h0, 4'd2, 3'd2);
        repeat (2) tick();
        chk("rq_sent_cred", credits, 11);
        for (int i = 0; i < 4; i++) ret(RT_WB, 32'h1000 + i);
        #1;
        chk("rq_cred", credits, 15);
        chk("rq_resp_v", resp_v, 1);
        chk("rq_full_ready", lout.rev_ready, 0);
        lin.rev_v = 1'b1; lin.rev.typ = RT_WB; lin.rev.data = 32'h1004;
        tick();
        #1;
        chk("rq_stalled_cred", credits, 15);
        chk("rq_head0", resp_data, 32'h1000);
        resp_yumi = 1'b1;
        tick();
        resp_yumi = 1'b0;
        #1;
        chk("rq_ready_again", lout.rev_ready, 1);
        tick();
        lin.rev_v = 1'b0;
        #1;
        chk("rq_5th_cred", credits, 16);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("rq_drain%0d", i), resp_data, 32'h1000 + i);
            resp_yumi = 1'b1;
            tick();
            resp_yumi = 1'b0;
        end
        #1;
        chk("rq_empty", resp_v, 0);

        // Fence waits for every outstanding return.
        do_reset();
        f0 = fires;
        for (int i = 0; i < 3; i++) push(OP_ST, A'(i), 32'h5, 4'd1, 3'd1);
        push(OP_FN, 28'h0, 32'h0, 4'd0, 3'd0);
        push(OP_ST, 28'h77, 32'h77, 4'd4, 3'd4);
        repeat (10) tick();
        chk("fn_fires", fires - f0, 3);
        chk("fn_held", lout.fwd_v, 0);
        chk("fn_credits", credits, 13);
        chk("fn_idle", idle, 0);
        ret(RT_CR, 32'h0);
        ret(RT_CR, 32'h0);
        #1;
        chk("fn_held_2ret", lout.fwd_v, 0);
        ret(RT_CR, 32'h0);
        #1;
        chk("fn_cred_full", credits, 16);
        chk("fn_held_3ret", lout.fwd_v, 0);
        tick();
        chk("fn_release_v", lout.fwd_v, 1);
        chk("fn_release_addr", lout.fwd.addr, 28'h77);
        tick();
        chk("fn_fires_after", fires - f0, 4);
        ret(RT_CR, 32'h0);
        #1;
        chk("fn_idle_end", idle, 1);

        // Watchdog with an 8-cycle limit.
        do_reset();
        push(OP_LD, 28'h300, 32'h0, 4'd3, 3'd3);
        tick();
        chk("wd_sent_cred", credits, 15);
        chk("wd_start", timeout, 0);
        repeat (6) tick();
        chk("wd_before_limit", timeout, 0);
        tick();
        chk("wd_at_limit", timeout, 1);
        ret(RT_WB, 32'hCAFE);
        #1;
        chk("wd_sticky", timeout, 1);
        chk("wd_late_cred", credits, 16);
        chk("wd_late_data", resp_data, 32'hCAFE);
        resp_yumi = 1'b1;
        tick();
        resp_yumi = 1'b0;
        tick();
        chk("wd_still_sticky", timeout, 1);
        do_reset();
        chk("wd_reset_clear", timeout, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
